// File: rtl/branch_predictor_ctrl_if.sv
// rtl/branch_predictor_ctrl_if.sv - fetch lookup and execute resolution signals of the branch predictor
interface branch_predictor_ctrl_if;
    logic [31:0] iFetchPC;
    logic        oPredTaken;
    logic [31:0] oPredTarget;
    logic        iUpdValid;
    logic [31:0] iUpdPC;
    logic        iUpdTaken;
    logic [31:0] iUpdTarget;
    logic        iUpdPredTaken;
    logic [31:0] iUpdPredTarget;
    logic        oFlush;
    logic [31:0] oRedirectPC;
    logic        oReady;
    logic [31:0] oMispredCount;

    modport master (
        output iFetchPC, iUpdValid, iUpdPC, iUpdTaken, iUpdTarget, iUpdPredTaken, iUpdPredTarget,
        input  oPredTaken, oPredTarget, oFlush, oRedirectPC, oReady, oMispredCount
    );

    modport slave (
        input  iFetchPC, iUpdValid, iUpdPC, iUpdTaken, iUpdTarget, iUpdPredTaken, iUpdPredTarget,
        output oPredTaken, oPredTarget, oFlush, oRedirectPC, oReady, oMispredCount
    );
endinterface

// File: rtl/branch_predictor_ctrl.sv
// rtl/branch_predictor_ctrl.sv - direct-mapped BHT/BTB predictor with misprediction flush
module branch_predictor_ctrl #(
    parameter int INDEX_BITS = 6
) (
    input  logic              iCLK,
    input  logic              iRST,
    branch_predictor_ctrl_if.slave bus
);
    localparam int TAG_BITS = 32 - INDEX_BITS - 2;
    localparam int ENTRIES  = 1 << INDEX_BITS;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t                state_q, state_d;
    logic [INDEX_BITS-1:0] init_idx_q;
    logic                  ready_q;
    logic                  flush_q;
    logic [31:0]           redirect_q;
    logic [31:0]           count_q;

    logic [1:0]            ctr_q    [ENTRIES];
    logic                  valid_q  [ENTRIES];
    logic [TAG_BITS-1:0]   tag_q    [ENTRIES];
    logic [31:0]           target_q [ENTRIES];

    logic [INDEX_BITS-1:0] f_idx, u_idx;
    logic [TAG_BITS-1:0]   f_tag, u_tag;
    logic                  upd_en, mispred, hit;
    logic [1:0]            ctr_next;

    assign f_idx = bus.iFetchPC[INDEX_BITS+1:2];
    assign f_tag = bus.iFetchPC[31:INDEX_BITS+2];
    assign u_idx = bus.iUpdPC[INDEX_BITS+1:2];
    assign u_tag = bus.iUpdPC[31:INDEX_BITS+2];

    assign upd_en  = (state_q == S_RUN) && bus.iUpdValid;
    assign mispred = (bus.iUpdTaken != bus.iUpdPredTaken) ||
                     (bus.iUpdTaken && bus.iUpdPredTaken && (bus.iUpdTarget != bus.iUpdPredTarget));

    // Lookup reads the pre-update table, so a same-cycle update is seen next cycle.
    assign hit = ready_q && ctr_q[f_idx][1] && valid_q[f_idx] && (tag_q[f_idx] == f_tag);

    assign bus.oPredTaken    = hit;
    assign bus.oPredTarget   = hit ? target_q[f_idx] : bus.iFetchPC + 32'd4;
    assign bus.oFlush        = flush_q;
    assign bus.oRedirectPC   = redirect_q;
    assign bus.oReady        = ready_q;
    assign bus.oMispredCount = count_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:  if (init_idx_q == '1) state_d = S_RUN;
            S_RUN:   state_d = S_RUN;
            default: state_d = S_INIT;
        endcase
    end

    always_comb begin
        ctr_next = ctr_q[u_idx];
        if (bus.iUpdTaken && (ctr_q[u_idx] != 2'b11))
            ctr_next = ctr_q[u_idx] + 2'b01;
        else if (!bus.iUpdTaken && (ctr_q[u_idx] != 2'b00))
            ctr_next = ctr_q[u_idx] - 2'b01;
    end

    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            state_q    <= S_INIT;
            init_idx_q <= '0;
            ready_q    <= 1'b0;
            flush_q    <= 1'b0;
            redirect_q <= '0;
            count_q    <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == S_RUN);
            if (state_q == S_INIT)
                init_idx_q <= init_idx_q + 1'b1;
            flush_q <= upd_en && mispred;
            if (upd_en && mispred) begin
                redirect_q <= bus.iUpdTaken ? bus.iUpdTarget : bus.iUpdPC + 32'd4;
                count_q    <= count_q + 32'd1;
            end
        end
    end

    // Table contents are left alone while reset is held; INIT rewrites every entry afterwards.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            if (state_q == S_INIT) begin
                ctr_q[init_idx_q]    <= 2'b01;
                valid_q[init_idx_q]  <= 1'b0;
                tag_q[init_idx_q]    <= '0;
                target_q[init_idx_q] <= '0;
            end else if (upd_en) begin
                ctr_q[u_idx] <= ctr_next;
                if (bus.iUpdTaken) begin
                    valid_q[u_idx]  <= 1'b1;
                    tag_q[u_idx]    <= u_tag;
                    target_q[u_idx] <= bus.iUpdTarget;
                end
            end
        end
    end
endmodule

// File: tb/tb_branch_predictor_ctrl.sv
// tb/tb_branch_predictor_ctrl.sv - directed and randomized checks of branch_predictor_ctrl against a table model
module tb_branch_predictor_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    branch_predictor_ctrl_if bus ();

    branch_predictor_ctrl dut (
        .iCLK (clk),
        .iRST (rst),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    int          m_ctr [64];
    bit          m_val [64];
    logic [23:0] m_tag [64];
    logic [31:0] m_tgt [64];
    int          m_init_left = 64;
    bit          m_ready = 0;
    bit          m_flush = 0;
    logic [31:0] m_redir = 0;
    logic [31:0] m_count = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit m_pt(input logic [31:0] pc);
        int i = int'(pc[7:2]);
        return m_ready && (m_ctr[i] >= 2) && m_val[i] && (m_tag[i] == pc[31:8]);
    endfunction

    function automatic logic [31:0] m_ptgt(input logic [31:0] pc);
        return m_pt(pc) ? m_tgt[int'(pc[7:2])] : pc + 32'd4;
    endfunction

    task automatic model_edge(input bit r, input bit uv, input logic [31:0] upc, input bit ut,
                              input logic [31:0] utgt, input bit upt, input logic [31:0] uptgt);
        int i;
        bit misp;
        if (!r) begin
            m_ready = 0; m_init_left = 64; m_flush = 0; m_redir = 0; m_count = 0;
        end else if (!m_ready) begin
            m_flush = 0;
            m_init_left--;
            if (m_init_left == 0) begin
                m_ready = 1;
                for (int k = 0; k < 64; k++) begin
                    m_ctr[k] = 1; m_val[k] = 0; m_tag[k] = 0; m_tgt[k] = 0;
                end
            end
        end else begin
            misp    = (ut != upt) || (ut && upt && (utgt != uptgt));
            m_flush = uv && misp;
            if (m_flush) begin
                m_redir = ut ? utgt : upc + 32'd4;
                m_count = m_count + 32'd1;
            end
            if (uv) begin
                i = int'(upc[7:2]);
                if (ut) begin
                    m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                    m_val[i] = 1; m_tag[i] = upc[31:8]; m_tgt[i] = utgt;
                end else begin
                    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                end
            end
        end
    endtask

    task automatic tick(input bit r, input logic [31:0] fpc, input bit uv, input logic [31:0] upc,
                        input bit ut, input logic [31:0] utgt, input bit upt, input logic [31:0] uptgt);
        @(negedge clk);
        rst = r;
        bus.iFetchPC = fpc;
        bus.iUpdValid = uv; bus.iUpdPC = upc; bus.iUpdTaken = ut; bus.iUpdTarget = utgt;
        bus.iUpdPredTaken = upt; bus.iUpdPredTarget = uptgt;
        #1;
        chk("pred_taken", {31'd0, bus.oPredTaken}, {31'd0, m_pt(fpc)});
        chk("pred_target", bus.oPredTarget, m_ptgt(fpc));
        @(posedge clk);
        model_edge(r, uv, upc, ut, utgt, upt, uptgt);
        #1;
        chk("ready", {31'd0, bus.oReady}, {31'd0, m_ready});
        chk("flush", {31'd0, bus.oFlush}, {31'd0, m_flush});
        chk("mispred_count", bus.oMispredCount, m_count);
        if (m_flush || !r) chk("redirect_pc", bus.oRedirectPC, m_redir);
    endtask

    task automatic idle(input logic [31:0] fpc);
        tick(1, fpc, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    endtask

    task automatic upd(input logic [31:0] fpc, input logic [31:0] upc, input bit ut,
                       input logic [31:0] utgt, input bit upt, input logic [31:0] uptgt);
        tick(1, fpc, 1, upc, ut, utgt, upt, uptgt);
    endtask

    logic [31:0] pcs [4];

    initial begin
        logic [31:0] fpc, upc, utgt, uptgt;
        bit          uv, ut, upt;
        pcs[0] = 32'h100; pcs[1] = 32'h200; pcs[2] = 32'h300; pcs[3] = 32'h1104;
        bus.iFetchPC = 0; bus.iUpdValid = 0; bus.iUpdPC = 0; bus.iUpdTaken = 0;
        bus.iUpdTarget = 0; bus.iUpdPredTaken = 0; bus.iUpdPredTarget = 0;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        tick(0, 32'h100, 0, 0, 0, 0, 0, 0);
        tick(0, 32'h100, 1, 32'h100, 1, 32'h200, 0, 32'h104);
        // INIT window with mispredicting updates that must be ignored
        for (int k = 0; k < 64; k++)
            tick(1, 32'h100 + 32'(k * 4), 1, 32'h100, 1, 32'h200, 0, 32'h104);

        upd(32'h100, 32'h100, 1, 32'h200, 0, 32'h104);
        idle(32'h100);
        repeat (3) upd(32'h100, 32'h100, 1, 32'h200, 1, 32'h200);
        idle(32'h100);
        upd(32'h100, 32'h100, 0, 32'h0, 1, 32'h200);
        upd(32'h100, 32'h100, 0, 32'h0, 1, 32'h200);
        idle(32'h100);
        upd(32'h200, 32'h100, 1, 32'h200, 0, 32'h104);
        idle(32'h200);
        idle(32'h100);
        upd(32'h100, 32'h100, 1, 32'h300, 1, 32'h200);
        upd(32'h100, 32'h100, 1, 32'h200, 1, 32'h300);
        idle(32'h100);
        upd(32'h100, 32'h100, 0, 32'h0, 1, 32'h200);
        tick(0, 32'h100, 1, 32'h100, 1, 32'h400, 0, 32'h104);
        tick(1, 32'h100, 0, 0, 0, 0, 0, 0);

        for (int n = 0; n < 400; n++) begin
            fpc   = ($urandom_range(0, 4) == 4) ? {$urandom} & 32'hFFFF_FFFC : pcs[$urandom_range(0, 3)];
            upc   = ($urandom_range(0, 4) == 4) ? {$urandom} & 32'hFFFF_FFFC : pcs[$urandom_range(0, 3)];
            uv    = ($urandom_range(0, 9) < 7);
            ut    = $urandom_range(0, 1) == 1;
            utgt  = ($urandom_range(0, 1) == 1) ? pcs[$urandom_range(0, 3)] + 32'h1000 : {$urandom} & 32'hFFFF_FFFC;
            if ($urandom_range(0, 1) == 1) begin
                upt = m_pt(upc); uptgt = m_ptgt(upc);
            end else begin
                upt = $urandom_range(0, 1) == 1; uptgt = upt ? utgt : upc + 32'd4;
            end
            tick((n != 150), fpc, uv, upc, ut, utgt, upt, uptgt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/branch_predictor_ctrl.md
Name: branch_predictor_ctrl

Overview:
Branch prediction and resolution controller for the pipelined core.
- Fetch side: a direct-mapped branch history table (BHT) of 2-bit saturating counters plus a branch target buffer (BTB) supplies a taken/target prediction for the fetch PC.
- Execute side: takes the resolved outcome from the branch comparator, trains the tables, and raises a one-cycle flush/redirect on misprediction.
- After reset, a self-initialisation sequence clears the tables before the block reports ready.

Parameters:
INDEX_BITS, 6, log2 of entry count (64 entries); index = PC[INDEX_BITS+1:2].
TAG_BITS, 32-INDEX_BITS-2, BTB tag width; tag = PC[31:INDEX_BITS+2]. Derived, not overridden.

Ports:
iCLK  input  1  core clock; all state updates on rising edge.
iRST  input  1  synchronous reset, active-low.
iFetchPC  input  32  PC being fetched.
oPredTaken  output  1  prediction for iFetchPC (combinational from table state).
oPredTarget  output  32  predicted target; iFetchPC+4 when oPredTaken=0.
iUpdValid  input  1  execute stage holds a resolved conditional branch this cycle.
iUpdPC  input  32  PC of the resolved branch.
iUpdTaken  input  1  actual outcome (branch comparator result).
iUpdTarget  input  32  actual taken target.
iUpdPredTaken  input  1  prediction that travelled down the pipe with this branch.
iUpdPredTarget  input  32  predicted target that travelled with it.
oFlush  output  1  one-cycle pulse: squash younger instructions.
oRedirectPC  output  32  correct next PC; valid when oFlush=1.
oReady  output  1  tables initialised; predictor active.
oMispredCount  output  32  count of mispredictions since reset.

Behaviour:
- Storage per entry: ctr[1:0], valid, tag[TAG_BITS-1:0], target[31:0].
- States:
  - INIT: entered on iRST=0 at any clock edge, including mid-operation. While iRST=0, forces init index=0 and clears all registered outputs.
  - INIT, each cycle after reset release: writes entry[initIdx] with ctr=2'b01, valid=0, tag=0, target=0, then increments initIdx. Transitions to RUN after writing entry 2^INDEX_BITS-1, so INIT lasts exactly 2^INDEX_BITS cycles after reset release.
  - RUN: normal operation; leaves RUN only on reset.
- Reset values: oFlush=0, oRedirectPC=0, oMispredCount=0, oReady=0.
- oReady is a registered output: 1 exactly while in RUN.
- Lookup (combinational):
  - oPredTaken = oReady & ctr[1] & valid & (tag == iFetchPC tag field).
  - oPredTarget = oPredTaken ? target : iFetchPC+4 (mod 2^32).
  - In INIT: oPredTaken=0 and oPredTarget=iFetchPC+4.
- Update, applied at the clock edge when iUpdValid=1 and in RUN. iUpdValid is ignored in INIT: no table write, no flush, no count.
  - Counter: taken increments, saturating at 2'b11; not-taken decrements, saturating at 2'b00.
  - BTB: on taken, writes valid=1, tag, target=iUpdTarget. On not-taken, valid/tag/target are unchanged.
  - An update whose tag mismatches the resident entry still trains the counter (aliasing is allowed).
- Mispredict = iUpdTaken != iUpdPredTaken, or (iUpdTaken & iUpdPredTaken & iUpdTarget != iUpdPredTarget).
  - On mispredict, the next cycle shows oFlush=1 (registered, 1-cycle latency) and oRedirectPC = iUpdTaken ? iUpdTarget : iUpdPC+4.
  - oFlush drops the following cycle unless another mispredicting update arrived.
  - oMispredCount increments by 1 on the same edge and wraps 0xFFFFFFFF -> 0.
- Simultaneous lookup and update to the same index: the lookup sees pre-update contents; the new value is visible the next cycle.
- Back-to-back updates on consecutive cycles are each applied. Consecutive mispredicts produce consecutive oFlush pulses, each with its own oRedirectPC.
- Reset asserted while oFlush=1: oFlush=0 on the next edge, and the pending redirect is discarded.

Test Plan:
- Reset, release, iUpdValid=1 during INIT -> oReady=0 for exactly 64 cycles, then 1; no oFlush; oMispredCount=0; any lookup returns not-taken, target PC+4.
- After ready, update PC=0x100 taken to 0x200 with pred 0/0x104 -> next cycle oFlush=1, oRedirectPC=0x200, count=1. Lookup 0x100 -> oPredTaken=1 (ctr 01->10), target 0x200.
- Train PC=0x100 taken 3 more times -> ctr saturates at 11. Then two not-taken updates -> ctr=01, lookup 0x100 predicts not-taken, target 0x104; the first not-taken mispredicts with redirect 0x104.
- Alias: train 0x100 taken to 0x200, then lookup 0x200 (same index, tag differs) -> oPredTaken=0, target 0x204.
- Correct-target mismatch: pred taken to 0x200, actual taken to 0x300 -> oFlush=1, oRedirectPC=0x300. Back-to-back second mispredict -> oFlush high two consecutive cycles, count +2.
- Lookup and update to 0x100 in the same cycle -> lookup shows old ctr. Assert iRST=0 mid-RUN with oFlush=1 -> next edge oFlush=0, oReady=0, count=0, INIT restarts.
